mem_stage_sram_ctrl: RTL and testbench

Multi-cycle controller between the pipeline MEM stage (driven by EX/MEM register outputs) and the external RAM1 asynchronous SRAM. It converts single-cycle memRead/memWrite requests into timed SRAM read and write sequences. It stalls the pipeline with memBusy while an access is in flight and returns read data to MEM/WB.

---
 rtl/mem_stage_sram_ctrl_if.sv | 24 ++
 rtl/mem_stage_sram_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side port bundle between the EX/MEM register and the MEM-stage SRAM controller.
// Handshake: memRead/memWrite are one-cycle requests seen while the controller idles; memBusy is
// asserted combinationally in that same cycle and held until the access completes, and the pipeline
// must freeze its registers (keeping the request fields stable is not required) while memBusy=1.
interface mem_stage_sram_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              memRead;
  logic              memWrite;
  logic [15:0]       address;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              memBusy;

  modport master (
    output memRead, memWrite, address, dataIn,
    input  dataOut, memBusy
  );

  modport slave (
    input  memRead, memWrite, address, dataIn,
    output dataOut, memBusy
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller for the RAM1 asynchronous SRAM: turns one-cycle load/store requests into
// timed OE/WE sequences, stalls the pipeline with memBusy, and registers read data for MEM/WB.
module mem_stage_sram_ctrl #(
  parameter int ACCESS_CYCLES = 2,
  parameter int RAM_ADDR_W    = 18,
  parameter int DATA_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  mem_stage_sram_ctrl_if.slave  memBus,
  output logic                  ram1OE,
  output logic                  ram1WE,
  output logic                  ram1EN,
  output logic [RAM_ADDR_W-1:0] ram1Addr,
  inout  wire  [DATA_W-1:0]     ram1Data,
  output logic [2:0]            stateDbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    WR_SETUP  = 3'd2,
    WR_PULSE  = 3'd3,
    WR_HOLD   = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic [DATA_W-1:0] wdataReg;
  logic [DATA_W-1:0] dataOutReg;
  logic              busDrive;
  logic              busy;
  logic              request;

  assign request = memBus.memRead | memBus.memWrite;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      ram1Addr   <= '0;
      wdataReg   <= '0;
      dataOutReg <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      // Address and store data are captured once so later pipeline churn cannot disturb the access.
      if (state == IDLE && request) begin
        ram1Addr <= RAM_ADDR_W'(memBus.address);
        wdataReg <= memBus.dataIn;
      end
      if (state == RD_ACCESS && cnt == LAST_CNT) begin
        dataOutReg <= ram1Data;
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    ram1EN    = 1'b1;
    ram1OE    = 1'b1;
    ram1WE    = 1'b1;
    busDrive  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy    = request;
        cntNext = 4'd0;
        if (memBus.memWrite) begin
          stateNext = WR_SETUP;
        end else if (memBus.memRead) begin
          stateNext = RD_ACCESS;
        end
      end
      RD_ACCESS: begin
        ram1EN = 1'b0;
        ram1OE = 1'b0;
        if (cnt == LAST_CNT) begin
          cntNext   = 4'd0;
          stateNext = DONE;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end
      WR_SETUP: begin
        ram1EN    = 1'b0;
        busDrive  = 1'b1;
        cntNext   = 4'd0;
        stateNext = WR_PULSE;
      end
      WR_PULSE: begin
        ram1EN   = 1'b0;
        ram1WE   = 1'b0;
        busDrive = 1'b1;
        if (cnt == LAST_CNT) begin
          cntNext   = 4'd0;
          stateNext = WR_HOLD;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end
      WR_HOLD: begin
        ram1EN    = 1'b0;
        busDrive  = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        // Requests seen here belong to the instruction that just finished, so they are dropped.
        busy      = 1'b0;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 4'd0;
      end
    endcase
  end

  assign ram1Data       = busDrive ? wdataReg : 'z;
  assign memBus.memBusy = busy;
  assign memBus.dataOut = dataOutReg;
  assign stateDbg       = state;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: one instance with ACCESS_CYCLES=2 and one with 1,
// each on its own behavioural SRAM that only commits writes whose WE pulse ran to full length.
module tb_mem_stage_sram_ctrl;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        sel      = 1'b0;
  logic        memRead  = 1'b0;
  logic        memWrite = 1'b0;
  logic [15:0] address  = 16'h0;
  logic [15:0] dataIn   = 16'h0;

  int nChecks = 0;
  int nPass   = 0;
  logic [15:0] expQ[$];

  mem_stage_sram_ctrl_if #(.DATA_W(16)) busA ();
  mem_stage_sram_ctrl_if #(.DATA_W(16)) busB ();

  assign busA.memRead  = memRead & ~sel;
  assign busA.memWrite = memWrite & ~sel;
  assign busA.address  = address;
  assign busA.dataIn   = dataIn;
  assign busB.memRead  = memRead & sel;
  assign busB.memWrite = memWrite & sel;
  assign busB.address  = address;
  assign busB.dataIn   = dataIn;

  logic        aOE, aWE, aEN, bOE, bWE, bEN;
  logic [17:0] aAddr, bAddr;
  logic [2:0]  aState, bState;
  wire  [15:0] aData, bData;

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(2), .RAM_ADDR_W(18), .DATA_W(16)) dutA (
    .CLK(CLK), .RST(RST), .memBus(busA),
    .ram1OE(aOE), .ram1WE(aWE), .ram1EN(aEN),
    .ram1Addr(aAddr), .ram1Data(aData), .stateDbg(aState)
  );

  mem_stage_sram_ctrl #(.ACCESS_CYCLES(1), .RAM_ADDR_W(18), .DATA_W(16)) dutB (
    .CLK(CLK), .RST(RST), .memBus(busB),
    .ram1OE(bOE), .ram1WE(bWE), .ram1EN(bEN),
    .ram1Addr(bAddr), .ram1Data(bData), .stateDbg(bState)
  );

  // ---------------- SRAM models ----------------
  logic [15:0] memA[0:255];
  logic [15:0] memB[0:255];
  logic        initA = 1'b0;
  logic        initB = 1'b0;
  int          weLowA, weLowB;
  logic [15:0] wdA, wdB;
  logic [7:0]  waA, waB;

  assign aData = (!aEN && !aOE) ? memA[aAddr[7:0]] : 'z;
  assign bData = (!bEN && !bOE) ? memB[bAddr[7:0]] : 'z;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      weLowA <= 0;
      if (!initA) begin
        for (int i = 0; i < 256; i++) memA[i] <= 16'hA500 | 16'(i);
        initA <= 1'b1;
      end
    end else if (!aEN && !aWE) begin
      weLowA <= weLowA + 1;
      wdA    <= aData;
      waA    <= aAddr[7:0];
    end else begin
      if (weLowA >= 2) memA[waA] <= wdA;
      weLowA <= 0;
    end
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      weLowB <= 0;
      if (!initB) begin
        for (int i = 0; i < 256; i++) memB[i] <= 16'hA500 | 16'(i);
        initB <= 1'b1;
      end
    end else if (!bEN && !bWE) begin
      weLowB <= weLowB + 1;
      wdB    <= bData;
      waB    <= bAddr[7:0];
    end else begin
      if (weLowB >= 1) memB[waB] <= wdB;
      weLowB <= 0;
    end
  end

  wire        obsOE   = sel ? bOE : aOE;
  wire        obsWE   = sel ? bWE : aWE;
  wire        obsEN   = sel ? bEN : aEN;
  wire [17:0] obsAddr = sel ? bAddr : aAddr;
  wire [15:0] obsData = sel ? bData : aData;
  wire        obsBusy = sel ? busB.memBusy : busA.memBusy;
  wire [15:0] obsDout = sel ? busB.dataOut : busA.dataOut;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the selected DUT idle; returns at the negedge of its DONE cycle.
  task automatic runAccess(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int expBusy, input int expWe, input int expOe);
    int busyCyc = 1;
    int weCyc = 0;
    int oeCyc = 0;
    int overlap = 0;
    int addrBad = 0;
    int dataBad = 0;
    bit done = 1'b0;
    logic [15:0] expDout;
    memRead  = rd;
    memWrite = wr;
    address  = addr;
    dataIn   = wdata;
    #1 check({tag, "_reqBusy"}, obsBusy, 1);
    @(negedge CLK);
    memRead  = 1'b0;
    memWrite = 1'b0;
    address  = ~addr;
    dataIn   = ~wdata;
    for (int c = 0; c < 40; c++) begin
      if (!obsBusy) begin
        done = 1'b1;
        break;
      end
      busyCyc++;
      if (!obsWE) weCyc++;
      if (!obsOE) oeCyc++;
      if (!obsWE && !obsOE) overlap++;
      if (obsAddr !== {2'b00, addr}) addrBad++;
      if (wr && !obsEN && obsOE && obsData !== wdata) dataBad++;
      @(negedge CLK);
    end
    check({tag, "_finished"}, done, 1);
    check({tag, "_busyCycles"}, busyCyc, expBusy);
    check({tag, "_weLowCycles"}, weCyc, expWe);
    check({tag, "_oeLowCycles"}, oeCyc, expOe);
    check({tag, "_oeWeOverlap"}, overlap, 0);
    check({tag, "_addrUnstable"}, addrBad, 0);
    check({tag, "_wdataBad"}, dataBad, 0);
    check({tag, "_doneStrobes"}, {obsEN, obsOE, obsWE}, 3'b111);
    if (expQ.size() == 0) begin
      check({tag, "_expQEmpty"}, 1, 0);
    end else begin
      expDout = expQ.pop_front();
      check({tag, "_dataOut"}, obsDout, expDout);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(negedge CLK);
    check("rst_busy", busA.memBusy, 0);
    check("rst_strobes", {aEN, aOE, aWE}, 3'b111);
    check("rst_addr", aAddr, 0);
    check("rst_dataOut", busA.dataOut, 0);
    check("rst_state", aState, 0);
    RST = 1'b1;
    @(negedge CLK);

    // 1: write 0xBEEF to 0x0010
    expQ.push_back(16'h0000);
    runAccess("t1_wr", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 5, 2, 0);
    @(negedge CLK);
    // 2: read it back
    expQ.push_back(16'hBEEF);
    runAccess("t2_rd", 1'b1, 1'b0, 16'h0010, 16'h0000, 3, 0, 2);
    @(negedge CLK);
    // 3: read+write together performs only the write
    expQ.push_back(16'hBEEF);
    runAccess("t3_rdwr", 1'b1, 1'b1, 16'h0020, 16'h1234, 5, 2, 0);
    @(negedge CLK);

    // 4: reset in the middle of the write pulse
    memWrite = 1'b1;
    address  = 16'h0030;
    dataIn   = 16'h5678;
    @(negedge CLK);
    memWrite = 1'b0;
    @(negedge CLK);
    check("t4_inPulse_we", aWE, 0);
    RST = 1'b0;
    #1;
    check("t4_rst_strobes", {aEN, aOE, aWE}, 3'b111);
    check("t4_rst_busy", busA.memBusy, 0);
    check("t4_rst_dataOut", busA.dataOut, 0);
    check("t4_rst_addr", aAddr, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    expQ.push_back(16'hA530);
    runAccess("t4_rdAfterAbort", 1'b1, 1'b0, 16'h0030, 16'h0000, 3, 0, 2);
    @(negedge CLK);

    // 5: back-to-back; a write request already present in DONE must wait for IDLE
    expQ.push_back(16'hBEEF);
    runAccess("t5_rd", 1'b1, 1'b0, 16'h0010, 16'h0000, 3, 0, 2);
    memWrite = 1'b1;
    address  = 16'h0011;
    dataIn   = 16'h00AA;
    #1 check("t5_doneNotBusy", obsBusy, 0);
    @(negedge CLK);
    expQ.push_back(16'hBEEF);
    runAccess("t5_wr", 1'b0, 1'b1, 16'h0011, 16'h00AA, 5, 2, 0);
    @(negedge CLK);
    expQ.push_back(16'h00AA);
    runAccess("t5_rdBack", 1'b1, 1'b0, 16'h0011, 16'h0000, 3, 0, 2);
    @(negedge CLK);

    // 6: ACCESS_CYCLES=1 instance
    sel = 1'b1;
    #1 check("t6_idleBusy", obsBusy, 0);
    @(negedge CLK);
    expQ.push_back(16'h0000);
    runAccess("t6_wr", 1'b0, 1'b1, 16'h0040, 16'h0F0F, 4, 1, 0);
    @(negedge CLK);
    expQ.push_back(16'h0F0F);
    runAccess("t6_rd", 1'b1, 1'b0, 16'h0040, 16'h0000, 2, 0, 1);
    @(negedge CLK);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
